// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin two-port sequencer for the shared data memory.
// Each access walks IDLE -> ACCESS -> RESP, serialising both requesters onto one memory port.
module data_mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic              err0_o,
  output logic              err1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              owner_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t              state_q;
  logic                last_q, owner_q, we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                grant_d, in_range, acc, rsp;
  logic [DATA_W-1:0]   rd;
  // On a tie the port that was not served last wins.
  assign grant_d = (req0_i & req1_i) ? ~last_q : req1_i;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (req0_i | req1_i) begin
          state_q <= ACCESS;
          owner_q <= grant_d;
          we_q    <= grant_d ? we1_i : we0_i;
          addr_q  <= grant_d ? addr1_i : addr0_i;
          wdata_q <= grant_d ? wdata1_i : wdata0_i;
        end
        ACCESS: state_q <= RESP;
        RESP: begin
          state_q <= IDLE;
          last_q  <= owner_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_range = addr_q < ADDR_W'(DEPTH);
  assign acc      = state_q == ACCESS;
  assign rsp      = state_q == RESP;
  // Gating with reset keeps an aborted write from landing on the negedge.
  assign mem_we_o    = acc & we_q & in_range & ~reset_i;
  assign mem_addr_o  = acc ? addr_q : '0;
  assign mem_wdata_o = acc ? wdata_q : '0;
  assign rd          = (rsp & ~we_q & in_range) ? mem_rdata_i : '0;
  assign ack0_o      = rsp & ~owner_q;
  assign ack1_o      = rsp & owner_q;
  assign err0_o      = ack0_o & ~in_range;
  assign err1_o      = ack1_o & ~in_range;
  assign rdata0_o    = ack0_o ? rd : '0;
  assign rdata1_o    = ack1_o ? rd : '0;
  assign busy_o      = state_q != IDLE;
  assign owner_o     = owner_q;
endmodule
